// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: load-size encodings, writeback FSM states and datapath widths.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        LS_WORD = 2'b00,
        LS_HALF = 2'b01,
        LS_BYTE = 2'b10
    } load_size_t;

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_extender.sv
// Combinational load formatter: picks the addressed half/byte lane and sign- or zero-extends it.
module load_extender
    import pipeline_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    output logic [DATA_W-1:0] data
);

    logic [15:0] half_lane;
    logic [7:0]  byte_lane;
    logic        fill;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
        byte_lane = rdata[7:0];
        case (offset)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase

        fill = 1'b0;
        data = rdata;
        case (load_size)
            LS_HALF: begin
                fill = ~load_unsigned & half_lane[15];
                data = {{16{fill}}, half_lane};
            end
            LS_BYTE: begin
                fill = ~load_unsigned & byte_lane[7];
                data = {{24{fill}}, byte_lane};
            end
            // Encoding 2'b11 falls through to a full-word load.
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: registers the MEM-stage result into the register-bank write port and
// stalls the pipeline while a load waits on data memory, with a sticky timeout flag.
module writeback_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 255
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic                  mem_read,
    input  logic [1:0]            mem_load_size,
    input  logic                  mem_load_unsigned,
    input  logic [DATA_W-1:0]     mem_alu_result,
    input  logic [REG_ADDR_W-1:0] mem_write_register,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_ready,
    input  logic                  flush,
    output logic                  Reg_write,
    output logic [REG_ADDR_W-1:0] write_register,
    output logic [DATA_W-1:0]     write_data,
    output logic                  wb_stall,
    output logic                  mem_error
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    wb_state_t         state;
    logic [CNT_W-1:0]  wait_count;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] capture_data;
    logic              run_stall;
    logic              run_capture;
    logic              wait_capture;
    logic              capture;

    load_extender u_load_extender (
        .rdata         (dmem_rdata),
        .offset        (mem_alu_result[1:0]),
        .load_size     (mem_load_size),
        .load_unsigned (mem_load_unsigned),
        .data          (load_data)
    );

    assign capture_data = mem_read ? load_data : mem_alu_result;
    assign run_stall    = mem_valid & mem_read & ~dmem_ready & ~flush;
    assign run_capture  = mem_valid & ~flush & ~(mem_read & ~dmem_ready);
    assign wait_capture = dmem_ready & ~flush;
    assign capture      = (state == RUN) ? run_capture : wait_capture;

    // Stall is combinational so upstream freezes in the same cycle a load misses; gating with
    // reset_n keeps it low while reset is asserted regardless of the inputs.
    assign wb_stall = reset_n & ((state == RUN) ? run_stall : ~wait_capture);

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RUN;
            wait_count     <= '0;
            Reg_write      <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
            mem_error      <= 1'b0;
        end else begin
            Reg_write <= 1'b0;
            if (capture) begin
                Reg_write      <= mem_valid & mem_reg_write & (mem_write_register != '0);
                write_register <= mem_write_register;
                write_data     <= capture_data;
            end

            case (state)
                RUN: begin
                    if (run_stall) begin
                        state      <= WAIT_MEM;
                        wait_count <= '0;
                    end
                end
                WAIT_MEM: begin
                    if (flush || dmem_ready) begin
                        state <= RUN;
                    end else begin
                        // Leaving on the last count means the counter stops at TIMEOUT and never wraps.
                        wait_count <= wait_count + CNT_W'(1);
                        if (wait_count == LAST_WAIT) begin
                            mem_error <= 1'b1;
                            state     <= RUN;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
